ofdm_mapper: RTL
================

Name: ofdm_mapper

Overview:
- IEEE 802.11a constellation mapper; sits directly downstream of the block interleaver.
- Consumes interleaved coded bits as bytes over AXI-Stream, LSB first in time, with a 4-bit rate tag.
- Emits one normalised complex I/Q sample per data subcarrier: 48 per OFDM symbol, BPSK/QPSK/16-QAM/64-QAM selected by rate.
- Feeds the pilot-insertion/IFFT stage.

Parameters:
- DW, 16, width of each of I and Q; signed Q2.14 (1.0 = 16384); only 16 is supported.

Ports:
- aclk  in  1  clock
- aresetn  in  1  synchronous active-low reset
- s_axis_tdata  in  8  interleaved coded bits; bit 0 is first in time
- s_axis_tuser  in  4  rate code (`RATE_* from ieee80211_defs.v)
- s_axis_tvalid  in  1  input valid
- s_axis_tready  out  1  input ready
- m_axis_tdata  out  32  {Q[15:0], I[15:0]}, two's complement
- m_axis_tuser  out  4  rate of the current symbol
- m_axis_tvalid  out  1  output valid
- m_axis_tready  in  1  output ready
- m_axis_tlast  out  1  last subcarrier of symbol (only with MAPPER_TLAST_EN)

Behaviour:
- Interface: reset is aresetn, synchronous, active-low; clock is aclk.
- Reset values: m_axis_tvalid=0, m_axis_tdata=0, m_axis_tuser=0, m_axis_tlast=0. Bit count, subcarrier index and latched rate clear to 0.
- Bit buffer: 13-bit shift buffer, buf_cnt 0..13. A new byte appends above the existing valid bits. Extraction takes the N_BPSC lowest bits, then shifts right by N_BPSC.
- N_BPSC by rate: 6M/9M=1, 12M/18M=2, 24M/36M=4, 48M/54M=6. Unknown codes map as BPSK.
- s_axis_tready = (buf_cnt < N_BPSC). Load and extract never occur in the same cycle.
- Rate latching: on a byte accepted while sc_idx==0 and buf_cnt==0, latch the rate from s_axis_tuser. The latched rate holds for all 48 subcarriers. tuser on the other bytes of the symbol is ignored.
- Symbol boundary: 48*N_BPSC is a multiple of 8, so the buffer is empty at every symbol boundary.
- Production: when buf_cnt >= N_BPSC and (~m_axis_tvalid | m_axis_tready):
  - register the mapped sample and set m_axis_tvalid=1;
  - reduce buf_cnt by N_BPSC;
  - sc_idx increments, wrapping 47->0.
- Latency: 1 cycle from the cycle buf_cnt reaches N_BPSC to tvalid.
- m_axis_tvalid falls after a handshake with no new sample ready.
- Output data and tuser hold stable while tvalid=1 and tready=0 (AXI rule).
- Mapping (Gray, b0 = first bit; Q=0 for BPSK):
  - BPSK: b0 0->-16384, 1->+16384.
  - QPSK: I from b0, Q from b1; 0->-11585, 1->+11585.
  - 16-QAM: I from b0b1, Q from b2b3. 00->-15543, 01->-5181, 11->+5181, 10->+15543.
  - 64-QAM: I from b0b1b2, Q from b3b4b5. 000->-17697, 001->-12641, 011->-7584, 010->-2528, 110->+2528, 111->+7584, 101->+12641, 100->+17697.
- Reset mid-symbol: the buffer, sc_idx and any pending output are discarded. The next accepted byte starts a new symbol.
- No other state machine: the block is in either AWAIT_SYMBOL (sc_idx==0, buf_cnt==0) or IN_SYMBOL. The transition occurs on the first accepted byte and returns after the 48th sample is produced.

Optional Feature:
- MAPPER_TLAST_EN defined:
  - m_axis_tlast port exists;
  - asserts with the sample of sc_idx 47 and holds with the data under backpressure.
- Undefined: the port is absent, and no tlast logic is built.

Decomposition:
- ieee80211_defs.v gains `N_BPSC_BPSK/QPSK/QAM16/QAM64 and amplitude constants:
  - `AMP_BPSK=16384;
  - `AMP_QPSK=11585;
  - `AMP_QAM16_1=5181, `AMP_QAM16_3=15543;
  - `AMP_QAM64_1=2528, `AMP_QAM64_3=7584, `AMP_QAM64_5=12641, `AMP_QAM64_7=17697.
- One combinational sub-module, mapper_lut: inputs rate class and 6 bits; outputs I and Q.

Test Plan:
- 6M, bytes 0xA5 then five of 0x00, tready=1 -> I sequence +16384,-16384,+16384,-16384,-16384,+16384,-16384,+16384, then 40 of -16384. Q=0 and tuser=6M throughout; tlast only on sample 48.
- 12M, first byte 0x1B -> (I,Q) = (+11585,+11585), (-11585,+11585), (+11585,-11585), (-11585,-11585); 12 bytes give exactly 48 samples.
- 24M, first byte 0x0D -> I=+15543, Q=+5181 for sample 0; 24 bytes give 48 samples; s_axis_tready drops while buf_cnt>=4.
- 54M, 36 bytes of 0xFF -> 48 samples of (+7584,+7584); buf_cnt==0 after the last sample. A following 6M symbol maps as BPSK even if tuser changes mid-symbol.
- Backpressure: hold m_axis_tready=0 for 10 cycles mid-symbol under 48M -> tdata, tuser and tlast stable; no sample lost or duplicated (48 per symbol, checked against a reference model with random tready/tvalid).
- Assert aresetn=0 for one cycle after 20 samples of a 36M symbol -> tvalid=0 the next cycle. A fresh 6M symbol is then mapped correctly starting at sc_idx 0.

Source files
------------

// File: rtl/ofdm_mapper_pkg.sv
// ofdm_mapper_pkg: 802.11a rate codes, N_BPSC, constellation amplitudes,
// modulation classes and Gray PAM helpers shared by the mapper files.
`timescale 1ns/1ps
package ofdm_mapper_pkg;

    // 4-bit RATE field codes
    localparam logic [3:0] RATE_6M  = 4'b1101;
    localparam logic [3:0] RATE_9M  = 4'b1111;
    localparam logic [3:0] RATE_12M = 4'b0101;
    localparam logic [3:0] RATE_18M = 4'b0111;
    localparam logic [3:0] RATE_24M = 4'b1001;
    localparam logic [3:0] RATE_36M = 4'b1011;
    localparam logic [3:0] RATE_48M = 4'b0001;
    localparam logic [3:0] RATE_54M = 4'b0011;

    localparam logic [3:0] N_BPSC_BPSK  = 4'd1;
    localparam logic [3:0] N_BPSC_QPSK  = 4'd2;
    localparam logic [3:0] N_BPSC_QAM16 = 4'd4;
    localparam logic [3:0] N_BPSC_QAM64 = 4'd6;

    // Q2.14 amplitudes, 1.0 = 16384
    localparam logic signed [15:0] AMP_BPSK    = 16'sd16384;
    localparam logic signed [15:0] AMP_QPSK    = 16'sd11585;
    localparam logic signed [15:0] AMP_QAM16_1 = 16'sd5181;
    localparam logic signed [15:0] AMP_QAM16_3 = 16'sd15543;
    localparam logic signed [15:0] AMP_QAM64_1 = 16'sd2528;
    localparam logic signed [15:0] AMP_QAM64_3 = 16'sd7584;
    localparam logic signed [15:0] AMP_QAM64_5 = 16'sd12641;
    localparam logic signed [15:0] AMP_QAM64_7 = 16'sd17697;

    typedef enum logic [1:0] {
        CLS_BPSK,
        CLS_QPSK,
        CLS_QAM16,
        CLS_QAM64
    } mod_cls_e;

    typedef enum logic {
        AWAIT_SYMBOL,
        IN_SYMBOL
    } sym_state_e;

    // Unknown rate codes fall back to BPSK.
    function automatic mod_cls_e rate_cls(input logic [3:0] rate);
        case (rate)
            RATE_12M, RATE_18M: return CLS_QPSK;
            RATE_24M, RATE_36M: return CLS_QAM16;
            RATE_48M, RATE_54M: return CLS_QAM64;
            default:            return CLS_BPSK;
        endcase
    endfunction

    function automatic logic [3:0] cls_nbpsc(input mod_cls_e c);
        case (c)
            CLS_QPSK:  return N_BPSC_QPSK;
            CLS_QAM16: return N_BPSC_QAM16;
            CLS_QAM64: return N_BPSC_QAM64;
            default:   return N_BPSC_BPSK;
        endcase
    endfunction

    // Gray 4-PAM: s is the first bit (sign), m selects inner point.
    function automatic logic signed [15:0] pam4(input logic s,
                                                 input logic m);
        logic signed [15:0] a;
        a = m ? AMP_QAM16_1 : AMP_QAM16_3;
        return s ? a : -a;
    endfunction

    // Gray 8-PAM: s is the first bit (sign), {m1,m0} the magnitude code.
    function automatic logic signed [15:0] pam8(input logic s,
                                                 input logic m1,
                                                 input logic m0);
        logic signed [15:0] a;
        case ({m1, m0})
            2'b00:   a = AMP_QAM64_7;
            2'b01:   a = AMP_QAM64_5;
            2'b11:   a = AMP_QAM64_3;
            default: a = AMP_QAM64_1;
        endcase
        return s ? a : -a;
    endfunction

endpackage

// File: rtl/mapper_lut.sv
// mapper_lut: combinational Gray constellation lookup, bits_i[0] first.
// Ports: cls_i modulation class, bits_i coded bits, i_o/q_o Q2.14 outputs.
`timescale 1ns/1ps
module mapper_lut
    import ofdm_mapper_pkg::*;
(
    input  mod_cls_e           cls_i,
    input  logic [5:0]         bits_i,
    output logic signed [15:0] i_o,
    output logic signed [15:0] q_o
);

    always_comb begin
        i_o = '0;
        q_o = '0;
        case (cls_i)
            CLS_QPSK: begin
                i_o = bits_i[0] ? AMP_QPSK : -AMP_QPSK;
                q_o = bits_i[1] ? AMP_QPSK : -AMP_QPSK;
            end
            CLS_QAM16: begin
                i_o = pam4(bits_i[0], bits_i[1]);
                q_o = pam4(bits_i[2], bits_i[3]);
            end
            CLS_QAM64: begin
                i_o = pam8(bits_i[0], bits_i[1], bits_i[2]);
                q_o = pam8(bits_i[3], bits_i[4], bits_i[5]);
            end
            default: begin
                i_o = bits_i[0] ? AMP_BPSK : -AMP_BPSK;
            end
        endcase
    end

endmodule

// File: rtl/ofdm_mapper.sv
// ofdm_mapper: 802.11a constellation mapper, bytes in (LSB first) and one
// Q2.14 I/Q sample per data subcarrier out, 48 per OFDM symbol.
// Ports: aclk/aresetn (sync, active low); s_axis_* bytes + rate tag;
// m_axis_* {Q,I} samples + rate; m_axis_tlast only with MAPPER_TLAST_EN.
`timescale 1ns/1ps
module ofdm_mapper
    import ofdm_mapper_pkg::*;
#(
    parameter int DW = 16
) (
    input  logic            aclk,
    input  logic            aresetn,
    input  logic [7:0]      s_axis_tdata,
    input  logic [3:0]      s_axis_tuser,
    input  logic            s_axis_tvalid,
    output logic            s_axis_tready,
    output logic [2*DW-1:0] m_axis_tdata,
    output logic [3:0]      m_axis_tuser,
    output logic            m_axis_tvalid,
`ifdef MAPPER_TLAST_EN
    output logic            m_axis_tlast,
`endif
    input  logic            m_axis_tready
);

    logic [12:0]     buf_q, buf_d;
    logic [3:0]      cnt_q, cnt_d;
    logic [5:0]      sc_q, sc_d;
    logic [3:0]      rate_q, rate_d;
    logic [2*DW-1:0] tdata_q, tdata_d;
    logic [3:0]      tuser_q, tuser_d;
    logic            tvalid_q, tvalid_d;
`ifdef MAPPER_TLAST_EN
    logic            tlast_q, tlast_d;
`endif

    mod_cls_e           cls;
    logic [3:0]         nbpsc;
    logic               load;
    logic               prod;
    sym_state_e         st;
    logic signed [15:0] lut_i;
    logic signed [15:0] lut_q;

    assign cls   = rate_cls(rate_q);
    assign nbpsc = cls_nbpsc(cls);

    // Ready only while a full sample cannot be formed, so a load and an
    // extraction never share a cycle.
    assign s_axis_tready = (cnt_q < nbpsc);
    assign load = s_axis_tvalid & s_axis_tready;
    assign prod = (cnt_q >= nbpsc) & (~tvalid_q | m_axis_tready);

    // The buffer is empty at every symbol boundary, so this pair of
    // conditions identifies the first byte of a symbol.
    assign st = (sc_q == 6'd0 && cnt_q == 4'd0) ? AWAIT_SYMBOL
                                                : IN_SYMBOL;

    mapper_lut u_lut (
        .cls_i  (cls),
        .bits_i (buf_q[5:0]),
        .i_o    (lut_i),
        .q_o    (lut_q)
    );

    always_comb begin
        buf_d    = buf_q;
        cnt_d    = cnt_q;
        sc_d     = sc_q;
        rate_d   = rate_q;
        tdata_d  = tdata_q;
        tuser_d  = tuser_q;
        tvalid_d = tvalid_q;
`ifdef MAPPER_TLAST_EN
        tlast_d  = tlast_q;
`endif
        if (load) begin
            buf_d = buf_q | ({5'd0, s_axis_tdata} << cnt_q);
            cnt_d = cnt_q + 4'd8;
            if (st == AWAIT_SYMBOL) begin
                rate_d = s_axis_tuser;
            end
        end
        if (prod) begin
            buf_d    = buf_q >> nbpsc;
            cnt_d    = cnt_q - nbpsc;
            sc_d     = (sc_q == 6'd47) ? 6'd0 : sc_q + 6'd1;
            tdata_d  = {lut_q, lut_i};
            tuser_d  = rate_q;
            tvalid_d = 1'b1;
`ifdef MAPPER_TLAST_EN
            tlast_d  = (sc_q == 6'd47);
`endif
        end else if (m_axis_tready) begin
            tvalid_d = 1'b0;
        end
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            buf_q    <= '0;
            cnt_q    <= '0;
            sc_q     <= '0;
            rate_q   <= '0;
            tdata_q  <= '0;
            tuser_q  <= '0;
            tvalid_q <= 1'b0;
`ifdef MAPPER_TLAST_EN
            tlast_q  <= 1'b0;
`endif
        end else begin
            buf_q    <= buf_d;
            cnt_q    <= cnt_d;
            sc_q     <= sc_d;
            rate_q   <= rate_d;
            tdata_q  <= tdata_d;
            tuser_q  <= tuser_d;
            tvalid_q <= tvalid_d;
`ifdef MAPPER_TLAST_EN
            tlast_q  <= tlast_d;
`endif
        end
    end

    assign m_axis_tdata  = tdata_q;
    assign m_axis_tuser  = tuser_q;
    assign m_axis_tvalid = tvalid_q;
`ifdef MAPPER_TLAST_EN
    assign m_axis_tlast  = tlast_q;
`endif

endmodule
